// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-decode arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default geometry, ID width derivation, popcount for the optional
// sequence checker.
package gray_pkg;

   localparam int GRAY_WIDTH_DEF = 4;
   localparam int GRAY_NREQ_DEF  = 4;

   // ID field width; a single requester still gets a 1-bit field so that the
   // port never collapses to zero width.
   function automatic int gray_id_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Number of set bits; WIDTH is at most 16, so callers zero-extend to 16.
   function automatic int unsigned gray_popcount(input logic [15:0] v);
      int unsigned c;
      c = 0;
      for (int k = 0; k < 16; k++) begin
         c = c + {31'd0, v[k]};
      end
      return c;
   endfunction

endpackage

// File: rtl/gray_to_bin_core.sv
// Purely combinational Gray-to-binary decoder, WIDTH bits.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_gray  in   WIDTH  Gray-coded word
//   o_bin   out  WIDTH  binary word
module gray_to_bin_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   // bin[k] is the XOR of all Gray bits from the MSB down to k; writing it as a
   // reduction of the shifted word avoids a bit-to-bit combinational chain on a
   // single vector.
   always_comb begin
      o_bin = '0;
      for (int k = 0; k < WIDTH; k++) begin
         o_bin[k] = ^(i_gray >> k);
      end
   end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin shares one Gray-to-binary decoder among N_REQ requesters.
// Latency: 1 cycle from accept (req_valid & req_ready) to out_valid.
// Backpressure: while out_valid && !out_ready no requester is granted and the output holds.
//
// Optional macro GRAY_SEQ_CHECK_EN: per-requester history flags any accepted
// Gray word that is not exactly one bit away from the previous one.
//
// Ports:
//   clk          in   1            rising-edge clock
//   rst          in   1            synchronous active-high reset
//   req_valid    in   N_REQ        per-requester request
//   req_gray     in   N_REQ*WIDTH  Gray words, requester i at [i*WIDTH +: WIDTH]
//   req_ready    out  N_REQ        one-hot grant or zero
//   out_valid    out  1            result valid
//   out_ready    in   1            consumer accepts result
//   out_bin      out  WIDTH        decoded binary word
//   out_id       out  ID_W         requester that produced out_bin
//   out_seq_err  out  1            sequence error (0 when checker disabled)
module gray_decode_arbiter
   import gray_pkg::*;
#(
   parameter int N_REQ = GRAY_NREQ_DEF,
   parameter int WIDTH = GRAY_WIDTH_DEF,
   parameter int ID_W  = gray_id_w(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_gray,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_bin,
   output logic [ID_W-1:0]        out_id,
   output logic                   out_seq_err
);

   logic [ID_W-1:0]  r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_bin;
   logic [ID_W-1:0]  r_out_id;

   logic [ID_W-1:0]  w_cand [N_REQ];
   logic             w_found;
   logic [ID_W-1:0]  w_gidx;
   logic             w_slot_free;
   logic             w_accept;
   logic [WIDTH-1:0] w_gray;
   logic [WIDTH-1:0] w_bin;
   logic [ID_W-1:0]  w_ptr_next;

   // Search order starts at the round-robin pointer and wraps mod N_REQ.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         w_cand[k] = ID_W'((int'(r_ptr) + k) % N_REQ);
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[w_cand[k]]) begin
            w_found = 1'b1;
            w_gidx  = w_cand[k];
         end
      end
   end

   // Grant depends only on req_valid, ptr, output occupancy and reset, never on
   // the Gray data, so req_ready has no path through the decoder.
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_accept    = w_found && w_slot_free && !rst;
   assign w_ptr_next  = ID_W'((int'(w_gidx) + 1) % N_REQ);

   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_gidx] = 1'b1;
      end
   end

   assign w_gray = req_gray[int'(w_gidx)*WIDTH +: WIDTH];

   gray_to_bin_core #(
      .WIDTH (WIDTH)
   ) u_dec (
      .i_gray (w_gray),
      .o_bin  (w_bin)
   );

   // Output register: EMPTY/FULL is simply r_out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_bin   <= '0;
         r_out_id    <= '0;
         r_ptr       <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_bin   <= w_bin;
         r_out_id    <= w_gidx;
         r_ptr       <= w_ptr_next;
      end else if (out_ready) begin
         // Drain: result consumed with nothing new to load.
         r_out_valid <= 1'b0;
      end
   end

`ifdef GRAY_SEQ_CHECK_EN
   logic [WIDTH-1:0] r_last [N_REQ];
   logic [N_REQ-1:0] r_seen;
   logic             r_seq_err;
   logic             w_step_bad;

   // A legal step changes exactly one bit; repeats and multi-bit jumps are bad.
   assign w_step_bad = (gray_popcount(16'(r_last[w_gidx] ^ w_gray)) != 32'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq_err <= 1'b0;
         r_seen    <= '0;
         for (int k = 0; k < N_REQ; k++) begin
            r_last[k] <= '0;
         end
      end else if (w_accept) begin
         // First word after reset has no predecessor to compare against.
         r_seq_err        <= r_seen[w_gidx] && w_step_bad;
         r_last[w_gidx]   <= w_gray;
         r_seen[w_gidx]   <= 1'b1;
      end
   end

   assign out_seq_err = r_seq_err;
`else
   assign out_seq_err = 1'b0;
`endif

   assign out_valid = r_out_valid;
   assign out_bin   = r_out_bin;
   assign out_id    = r_out_id;

endmodule
